// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew feeder between the per-row input FIFOs and the west edge of a systolic PE array.
// Row i is popped i steps after row 0; any empty FIFO that must be popped freezes the whole wavefront.
module systolic_skew_feeder #(
  parameter int ROWS      = 32,
  parameter int ROWS_LOG2 = 5,
  parameter int BWIDTH    = 8,
  parameter int LEN_W     = 8
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     START,
  input  logic [LEN_W-1:0]         LEN,
  input  logic [ROWS-1:0]          FIFO_EMPTY,
  input  logic [ROWS*BWIDTH-1:0]   FIFO_DOUT,
  output logic [ROWS-1:0]          FIFO_POPE,
  output logic [ROWS*BWIDTH-1:0]   PE_DATA,
  output logic [ROWS-1:0]          PE_VALID,
  output logic                     BUSY,
  output logic                     STALL,
  output logic                     DONE
);

  localparam int CW = LEN_W + ROWS_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic [CW-1:0]            t_r, t_s;
  logic [LEN_W-1:0]         len_r, len_s;
  logic [CW-1:0]            last_t_s;
  logic [ROWS-1:0]          active_s;
  logic [ROWS-1:0]          pope_s;
  logic [ROWS-1:0]          valid_s;
  logic [ROWS*BWIDTH-1:0]   data_s;
  logic                     stall_s;
  logic [ROWS*BWIDTH-1:0]   pe_data_r;
  logic [ROWS-1:0]          pe_valid_r;

  // Lane activity window i <= t < i+LEN, evaluated at full counter width so nothing wraps.
  always_comb begin
    active_s = '0;
    last_t_s = CW'(len_r) + CW'(ROWS - 2);
    for (int i = 0; i < ROWS; i++) begin
      active_s[i] = (t_r >= CW'(i)) && (t_r < (CW'(i) + CW'(len_r)));
    end
  end

  // Next-state, step counter and pop/data decode.
  always_comb begin
    state_s = state_r;
    t_s     = t_r;
    len_s   = len_r;
    pope_s  = '0;
    valid_s = '0;
    data_s  = '0;
    stall_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          len_s = LEN;
          t_s   = '0;
          if (LEN != '0) begin
            state_s = S_RUN;
          end else begin
            state_s = S_FIN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        stall_s = |(active_s & FIFO_EMPTY);
        if (stall_s) begin
          t_s = t_r;
        end else begin
          pope_s  = active_s;
          valid_s = active_s;
          for (int i = 0; i < ROWS; i++) begin
            if (active_s[i]) begin
              data_s[i*BWIDTH +: BWIDTH] = FIFO_DOUT[i*BWIDTH +: BWIDTH];
            end else begin
              data_s[i*BWIDTH +: BWIDTH] = '0;
            end
          end
          if (t_r == last_t_s) begin
            state_s = S_FIN;
          end else begin
            t_s = t_r + CW'(1);
          end
        end
      end
      S_FIN: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Control state, step counter and latched pass length.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= S_IDLE;
      t_r     <= '0;
      len_r   <= '0;
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      len_r   <= len_s;
    end
  end

  // West-edge operand and valid registers; zero whenever no pop happened.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pe_data_r  <= '0;
      pe_valid_r <= '0;
    end else begin
      pe_data_r  <= data_s;
      pe_valid_r <= valid_s;
    end
  end

  assign FIFO_POPE = pope_s;
  assign STALL     = stall_s;
  assign PE_DATA   = pe_data_r;
  assign PE_VALID  = pe_valid_r;
  assign BUSY      = (state_r != S_IDLE);
  assign DONE      = (state_r == S_FIN);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with ROWS=4: skew, stall, LEN=0/1/255, START-while-busy and mid-pass reset.
module tb_systolic_skew_feeder;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         START = 1'b0;
  logic [7:0]   LEN = 8'd0;
  logic [3:0]   FIFO_EMPTY;
  logic [31:0]  FIFO_DOUT;
  logic [3:0]   FIFO_POPE;
  logic [31:0]  PE_DATA;
  logic [3:0]   PE_VALID;
  logic         BUSY, STALL, DONE;

  int checks = 0;
  int errors = 0;
  int beats [4];

  logic [7:0] mem [4][512];
  logic [8:0] wr_ptr [4];
  logic [8:0] rd_ptr [4];
  logic [3:0] force_empty = 4'b0000;

  logic [3:0] skew_pope  [7]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] skew_valid [7]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] st_pope    [10] = '{4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] st_valid   [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0000,
                                  4'b0000, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] one_pope   [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [3:0] one_valid  [5]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  systolic_skew_feeder #(.ROWS(4), .ROWS_LOG2(2), .BWIDTH(8), .LEN_W(8)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .LEN(LEN),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DOUT(FIFO_DOUT), .FIFO_POPE(FIFO_POPE),
    .PE_DATA(PE_DATA), .PE_VALID(PE_VALID), .BUSY(BUSY), .STALL(STALL), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Row FIFO models: front element is combinational, pops advance at the edge, reset empties them.
  always_comb begin
    FIFO_EMPTY = '0;
    FIFO_DOUT  = '0;
    for (int i = 0; i < 4; i++) begin
      FIFO_EMPTY[i]      = (rd_ptr[i] == wr_ptr[i]) | force_empty[i];
      FIFO_DOUT[i*8 +: 8] = mem[i][rd_ptr[i]];
    end
  end

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 4; i++) rd_ptr[i] <= wr_ptr[i];
    end else begin
      for (int i = 0; i < 4; i++) if (FIFO_POPE[i]) rd_ptr[i] <= rd_ptr[i] + 9'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RSTn === 1'b1) chk("pop_to_empty", 32'(FIFO_POPE & FIFO_EMPTY), 32'd0);
  end

  task automatic push(input int r, input logic [7:0] v);
    mem[r][wr_ptr[r]] = v;
    wr_ptr[r] = wr_ptr[r] + 9'd1;
  endtask

  task automatic preload(input int n, input int off);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < n; k++) push(i, 8'(off + 16*i + k));
    for (int i = 0; i < 4; i++) beats[i] = 0;
  endtask

  task automatic tick(input logic [3:0] fe);
    @(posedge CLK);
    #1;
    force_empty = fe;
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic [3:0] ep, input logic [3:0] ev,
                             input logic eb, input logic ed, input logic es, input int off);
    logic [31:0] exp_data;
    exp_data = '0;
    for (int i = 0; i < 4; i++)
      if (ev[i]) exp_data[i*8 +: 8] = 8'(off + 16*i + beats[i]);
    chk({tag, "_pope"},  32'(FIFO_POPE), 32'(ep));
    chk({tag, "_valid"}, 32'(PE_VALID),  32'(ev));
    chk({tag, "_data"},  PE_DATA,        exp_data);
    chk({tag, "_busy"},  32'(BUSY),      32'(eb));
    chk({tag, "_done"},  32'(DONE),      32'(ed));
    chk({tag, "_stall"}, 32'(STALL),     32'(es));
    for (int i = 0; i < 4; i++) if (ev[i]) beats[i]++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_pope"},  32'(FIFO_POPE), 32'd0);
    chk({tag, "_valid"}, 32'(PE_VALID),  32'd0);
    chk({tag, "_data"},  PE_DATA,        32'd0);
    chk({tag, "_busy"},  32'(BUSY),      32'd0);
    chk({tag, "_done"},  32'(DONE),      32'd0);
    chk({tag, "_stall"}, 32'(STALL),     32'd0);
  endtask

  int run_cyc, done_cnt;
  int pops [4];
  logic [31:0] exp_long;

  initial begin
    for (int i = 0; i < 4; i++) begin
      wr_ptr[i] = 9'd0;
      beats[i]  = 0;
    end

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    check_idle("reset");
    RSTn = 1'b1;

    // Skew pass LEN=3, with an ignored START at RUN cycle 3
    preload(3, 0);
    LEN = 8'd3;
    START = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick(4'b0000);
      START = (c == 2);
      LEN   = (c == 2) ? 8'd7 : 8'd3;
      check_cycle("skew", skew_pope[c], skew_valid[c], 1'b1, (c == 6), 1'b0, 0);
    end
    tick(4'b0000);
    check_idle("skew_end");

    // Stall: row 2 seen empty for three cycles starting at step 2
    preload(3, 8'h80);
    START = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick((c >= 2 && c <= 4) ? 4'b0100 : 4'b0000);
      START = 1'b0;
      check_cycle("stall", st_pope[c], st_valid[c], 1'b1, (c == 9), (c >= 2 && c <= 4), 8'h80);
    end
    tick(4'b0000);
    check_idle("stall_end");

    // LEN=0: straight to FIN, no pops
    LEN = 8'd0;
    START = 1'b1;
    tick(4'b0000);
    START = 1'b0;
    check_cycle("len0", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 0);
    tick(4'b0000);
    check_idle("len0_end");

    // LEN=1 with an extra entry left in each FIFO: inactive lanes must read as zero
    preload(2, 8'h40);
    LEN = 8'd1;
    START = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(4'b0000);
      START = 1'b0;
      check_cycle("len1", one_pope[c], one_valid[c], 1'b1, (c == 4), 1'b0, 8'h40);
    end
    tick(4'b0000);
    check_idle("len1_end");

    // Reset in the middle of a pass, then a full pass afterwards
    preload(3, 8'h08);
    LEN = 8'd3;
    START = 1'b1;
    tick(4'b0000);
    START = 1'b0;
    tick(4'b0000);
    RSTn = 1'b0;
    #1;
    check_idle("midrst");
    @(posedge CLK);
    #2;
    check_idle("midrst_hold");
    RSTn = 1'b1;
    preload(3, 8'hC0);
    START = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick(4'b0000);
      START = 1'b0;
      check_cycle("postrst", skew_pope[c], skew_valid[c], 1'b1, (c == 6), 1'b0, 8'hC0);
    end
    tick(4'b0000);
    check_idle("postrst_end");

    // Counter bound LEN=255
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 255; k++) push(i, 8'(k));
      beats[i] = 0;
      pops[i]  = 0;
    end
    run_cyc  = 0;
    done_cnt = 0;
    LEN = 8'd255;
    START = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick(4'b0000);
      START = 1'b0;
      if (BUSY && !DONE) run_cyc++;
      if (DONE) done_cnt++;
      exp_long = '0;
      for (int i = 0; i < 4; i++) begin
        if (FIFO_POPE[i]) pops[i]++;
        if (PE_VALID[i]) begin
          exp_long[i*8 +: 8] = 8'(beats[i]);
          beats[i]++;
        end
      end
      chk("long_data", PE_DATA, exp_long);
      if (!BUSY) break;
    end
    chk("long_run_cycles", 32'(run_cyc), 32'd258);
    chk("long_done_count", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("long_pops", 32'(pops[i]), 32'd255);
      chk("long_beats", 32'(beats[i]), 32'd255);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
